// File: rtl/clkdiv_toggle_gen_if.sv
// Control and edge-toggle output bundle for clkdiv_toggle_gen.
// The master drives run/divisor controls and the slave returns the toggles, strobes and running flag.
interface clkdiv_toggle_gen_if #(
    parameter int W_DIV = 8
);
    logic             en;
    logic [W_DIV-1:0] div;
    logic             div_update;
    logic             rise_tog;
    logic             fall_tog;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             running;

    modport master (
        output en, div, div_update,
        input  rise_tog, fall_tog, rise_pulse, fall_pulse, running
    );

    modport slave (
        input  en, div, div_update,
        output rise_tog, fall_tog, rise_pulse, fall_pulse, running
    );
endinterface

// File: rtl/clkdiv_toggle_gen.sv
// Programmable clock divider emitting the output clock as a rise/fall toggle pair.
// The output clock is rise_tog ^ fall_tog; only one toggle changes per clk edge.
module clkdiv_toggle_gen #(
    parameter int W_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    clkdiv_toggle_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [W_DIV-1:0] DIV_MIN = W_DIV'(2);
    localparam logic [W_DIV-1:0] CTR_ONE = W_DIV'(1);

    // Divisors 0 and 1 cannot form a high and a low phase, so they clamp to 2.
    function automatic logic [W_DIV-1:0] eff_div(input logic [W_DIV-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    function automatic logic [W_DIV-1:0] high_len(input logic [W_DIV-1:0] ne);
        return ne - (ne >> 1);
    endfunction

    function automatic logic [W_DIV-1:0] low_len(input logic [W_DIV-1:0] ne);
        return ne >> 1;
    endfunction

    state_t           state_q,       state_d;
    logic [W_DIV-1:0] ctr_q,         ctr_d;
    logic [W_DIV-1:0] div_pending_q, div_pending_d;
    logic [W_DIV-1:0] div_active_q,  div_active_d;
    logic             rise_tog_q,    rise_tog_d;
    logic             fall_tog_q,    fall_tog_d;
    logic             rise_pulse_q,  rise_pulse_d;
    logic             fall_pulse_q,  fall_pulse_d;
    logic             running_q,     running_d;
    logic             start_rise;

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        div_pending_d = bus.div_update ? bus.div : div_pending_q;
        div_active_d  = div_active_q;
        rise_tog_d    = rise_tog_q;
        fall_tog_d    = fall_tog_q;
        rise_pulse_d  = 1'b0;
        fall_pulse_d  = 1'b0;
        running_d     = running_q;
        start_rise    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start_rise = bus.en;
            end
            ST_HIGH: begin
                if (ctr_q == '0) begin
                    state_d      = ST_LOW;
                    fall_tog_d   = ~fall_tog_q;
                    fall_pulse_d = 1'b1;
                    ctr_d        = low_len(eff_div(div_active_q)) - CTR_ONE;
                end else begin
                    ctr_d = ctr_q - CTR_ONE;
                end
            end
            ST_LOW: begin
                // en is only consulted at the end of LOW, so a stop never truncates a phase.
                if (ctr_q == '0) begin
                    if (bus.en) begin
                        start_rise = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        running_d = 1'b0;
                    end
                end else begin
                    ctr_d = ctr_q - CTR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new period adopts the pending divisor; the period in flight never sees it.
        if (start_rise) begin
            state_d      = ST_HIGH;
            div_active_d = div_pending_q;
            ctr_d        = high_len(eff_div(div_pending_q)) - CTR_ONE;
            rise_tog_d   = ~rise_tog_q;
            rise_pulse_d = 1'b1;
            running_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ctr_q         <= '0;
            div_pending_q <= DIV_MIN;
            div_active_q  <= DIV_MIN;
            rise_tog_q    <= 1'b0;
            fall_tog_q    <= 1'b0;
            rise_pulse_q  <= 1'b0;
            fall_pulse_q  <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            div_pending_q <= div_pending_d;
            div_active_q  <= div_active_d;
            rise_tog_q    <= rise_tog_d;
            fall_tog_q    <= fall_tog_d;
            rise_pulse_q  <= rise_pulse_d;
            fall_pulse_q  <= fall_pulse_d;
            running_q     <= running_d;
        end
    end

    assign bus.rise_tog   = rise_tog_q;
    assign bus.fall_tog   = fall_tog_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.fall_pulse = fall_pulse_q;
    assign bus.running    = running_q;

endmodule

// File: tb/tb_clkdiv_toggle_gen.sv
// Scoreboard bench for clkdiv_toggle_gen: a waveform-queue reference model predicts every cycle's outputs.
module tb_clkdiv_toggle_gen;

    localparam int W_DIV = 8;

    typedef struct packed {
        logic clk_out;
        logic rise_tog;
        logic fall_tog;
        logic rise_pulse;
        logic fall_pulse;
        logic running;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clkdiv_toggle_gen_if #(.W_DIV(W_DIV)) ifc ();

    clkdiv_toggle_gen #(.W_DIV(W_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cycle   = 0;
    bit   started = 1'b0;
    bit   stop    = 1'b0;

    // Reference model: a started period appends H ones and L zeros to a level queue.
    bit   wave[$];
    int   m_pend = 2;
    int   m_act  = 2;
    bit   m_rt   = 1'b0;
    bit   m_ft   = 1'b0;
    bit   m_lvl  = 1'b0;

    task automatic model_edge();
        exp_t e;
        int   ne;
        bit   rp;
        bit   fp;
        bit   run;
        bit   lvl;
        rp = 1'b0; fp = 1'b0; run = 1'b0; lvl = 1'b0;
        if (rst) begin
            wave.delete();
            m_pend = 2;
            m_act  = 2;
            m_rt   = 1'b0;
            m_ft   = 1'b0;
            m_lvl  = 1'b0;
        end else begin
            if (wave.size() == 0 && ifc.en) begin
                m_act = m_pend;
                ne = (m_act < 2) ? 2 : m_act;
                repeat ((ne + 1) / 2) wave.push_back(1'b1);
                repeat (ne / 2) wave.push_back(1'b0);
                rp = 1'b1;
            end
            if (wave.size() > 0) begin
                lvl = wave.pop_front();
                run = 1'b1;
                if (!lvl && m_lvl) fp = 1'b1;
            end
            if (rp) m_rt = ~m_rt;
            if (fp) m_ft = ~m_ft;
            m_lvl = lvl;
            if (ifc.div_update) m_pend = int'(ifc.div);
        end
        e.clk_out    = m_rt ^ m_ft;
        e.rise_tog   = m_rt;
        e.fall_tog   = m_ft;
        e.rise_pulse = rp;
        e.fall_pulse = fp;
        e.running    = run;
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit en, input logic [W_DIV-1:0] d, input bit upd);
        @(negedge clk);
        rst            = r;
        ifc.en         = en;
        ifc.div        = d;
        ifc.div_update = upd;
        model_edge();
        started = 1'b1;
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cycle);
        end
    endfunction

    always @(posedge clk) begin
        exp_t e;
        cycle++;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("clk_out",    ifc.rise_tog ^ ifc.fall_tog, e.clk_out);
            chk("rise_tog",   ifc.rise_tog,   e.rise_tog);
            chk("fall_tog",   ifc.fall_tog,   e.fall_tog);
            chk("rise_pulse", ifc.rise_pulse, e.rise_pulse);
            chk("fall_pulse", ifc.fall_pulse, e.fall_pulse);
            chk("running",    ifc.running,    e.running);
            chk("pulse_exclusive", !(ifc.rise_pulse && ifc.fall_pulse), 1'b1);
            if (!e.running) chk("idle_toggles_equal", ifc.rise_tog ^ ifc.fall_tog, 1'b0);
        end else if (started && !stop) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation, required one at cycle %0d", cycle);
        end
    end

    initial begin
        ifc.en         = 1'b0;
        ifc.div        = '0;
        ifc.div_update = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
        idle(2);

        // Divide by 4, then odd divisor 5, then clamped 0 and 1.
        step(1'b0, 1'b0, 8'd4, 1'b1);
        run_en(12);
        step(1'b0, 1'b1, 8'd5, 1'b1);
        run_en(15);
        step(1'b0, 1'b1, 8'd0, 1'b1);
        run_en(8);
        step(1'b0, 1'b1, 8'd1, 1'b1);
        run_en(8);
        idle(6);

        // Divisor change requested mid-HIGH of an 8-cycle period.
        step(1'b0, 1'b0, 8'd8, 1'b1);
        run_en(2);
        step(1'b0, 1'b1, 8'd3, 1'b1);
        run_en(14);
        idle(10);

        // Graceful stop: en held only for the first HIGH cycle.
        step(1'b0, 1'b0, 8'd6, 1'b1);
        step(1'b0, 1'b1, 8'd0, 1'b0);
        idle(10);

        // en dips for one and for two cycles within a period.
        run_en(3);
        idle(1);
        run_en(4);
        idle(2);
        run_en(6);
        idle(8);

        // Reset mid-HIGH, then restart with the default divisor.
        step(1'b0, 1'b0, 8'd9, 1'b1);
        run_en(3);
        step(1'b1, 1'b1, 8'd0, 1'b0);
        run_en(6);
        idle(4);

        // Randomised operation with rare resets and occasional large divisors.
        for (int i = 0; i < 1500; i++) begin
            bit               r;
            bit               e;
            bit               u;
            logic [W_DIV-1:0] d;
            r = ($urandom_range(0, 249) == 0);
            e = ($urandom_range(0, 9) < 7);
            u = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 19) == 0) ? W_DIV'($urandom_range(13, 40))
                                             : W_DIV'($urandom_range(0, 12));
            step(r, e, d, u);
        end
        idle(2);

        @(posedge clk);
        #3;
        stop = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
